fdiv_bfloat16_seq: RTL and testbench
====================================

// Module: fdiv_bfloat16_seq
// PURPOSE
//  Iterative bfloat16 divider (q = a / b), the inverse of the bfloat16 multiplier datapath.
//  Restoring radix-2 mantissa division, one quotient bit per clock.
//  Truncation rounding; the exponent uses the same bias-127 arithmetic as the multiplier.
//  Sits between the operand BRAM readers and the ILA/result capture, behind a valid/ready handshake.
// PARAMETERS
//  QBITS   9      quotient bits produced: 1 integer + 8 fraction; fixed by bfloat16, do not override
//  BIAS    127    bfloat16 exponent bias
// PORTS
//  clk        in   1   single clock, all logic rising-edge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   operands a/b valid
//  in_ready   out  1   block idle, can accept operands
//  a          in   16  dividend, bfloat16 {s,e[7:0],m[6:0]}
//  b          in   16  divisor, bfloat16
//  out_valid  out  1   quotient valid; held until accepted
//  out_ready  in   1   downstream accepts quotient
//  q          out  16  quotient, bfloat16
//  busy       out  1   high in CALC or DONE
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; busy=0; q=16'h0000; internal regs cleared.
//  FSM: IDLE -> CALC (normal operands) | DONE (special operands); CALC -> DONE after 9 iterations.
//       DONE -> IDLE when out_ready=1.
//  in_ready = (state==IDLE). Accept = in_valid & in_ready, sampled on the rising edge.
//    Registers ma={1,a[6:0]}, mb={1,b[6:0]} (8b), sign=a[15]^b[15].
//    Registers e = {2'b0,a[14:7]} - {2'b0,b[14:7]} + 127 (10-bit signed).
//  Classification at accept, in priority order; special cases go straight to DONE:
//    1. NaN: both a and b are zero, or both have exp==255 -> q=16'h7FC0 (sign ignored).
//    2. b exp==0 (zero; denormals flushed), or a exp==255 -> q={sign,8'hFF,7'h00}.
//    3. a exp==0, or b exp==255 -> q={sign,15'h0}.
//    4. Otherwise normal -> CALC. Mantissa bits of any exp==255 operand are ignored.
//  Special-case latency: out_valid rises on the first edge after accept.
//  CALC: 10-bit remainder r, initialised to ma at accept; iteration counter 0..8.
//    Each cycle: if r>=mb then qb=1, r=r-mb, else qb=0.
//    Then r=r<<1 and quot={quot[7:0],qb}.
//    The first bit produced is quot[8] (the integer bit).
//  Normalise on the 9th cycle, registered into q as out_valid rises:
//    quot[8]=1 -> mant=quot[7:1], exp=e.
//    quot[8]=0 -> mant=quot[6:0], exp=e-1 (quot[7] is always 1 here).
//    exp>=255 -> q={sign,8'hFF,7'h0} (overflow to inf).
//    exp<=0 -> q={sign,15'h0} (underflow flush).
//    Otherwise q={sign,exp[7:0],mant}.
//  Normal latency: out_valid rises exactly 9 edges after the accept edge.
//  DONE: out_valid=1, q stable while out_ready=0; no new accept.
//    On the edge with out_ready=1: out_valid=0 and state=IDLE; in_ready rises next cycle.
//    No same-cycle accept while in DONE.
//  Reset mid-operation (CALC or DONE): the operation is dropped and no out_valid pulse follows.
//  in_valid while busy is ignored; operands must be held until accepted.
//  a and b must not change while in_valid=1 and in_ready=1.
// TESTING
//  1. a=16'h3FC0 (1.5), b=16'h4000 (2.0) -> q=16'h3F40 (0.75), out_valid 9 cycles after accept.
//  2. a=16'h3F80 (1.0), b=16'h4040 (3.0) -> q=16'h3EAA (truncated 0.333); quot=9'b010101010.
//  3. a=16'hC000, b=16'h0000 -> q=16'hFF80 one cycle after accept. a=0, b=0 -> q=16'h7FC0.
//  4. a=16'h7F00, b=16'h0080 -> q=16'h7F80 (overflow). a=16'h0080, b=16'h7F00 -> q=16'h0000.
//  5. Hold out_ready=0 for 20 cycles after out_valid -> q/out_valid stable, in_ready=0.
//     Then release -> in_ready=1 next cycle; back-to-back ops give correct results.
//  6. Assert rst in CALC iteration 4 -> next cycle in_ready=1, out_valid=0.
//     No stale result appears; the next op is computed correctly.

Source files
------------

// File: rtl/fdiv_bfloat16_seq.sv
// fdiv_bfloat16_seq
//   Iterative bfloat16 divider, q = a / b. The mantissas are divided by a
//   restoring radix-2 loop that retires one quotient bit per clock, giving
//   9 quotient bits: 1 integer bit and 8 fraction bits. The result is
//   truncated. Special operands (zero, inf, NaN) skip the loop and go
//   straight to the result state. Denormal operands are flushed to zero.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands a/b valid
//   in_ready   high when idle and able to accept operands
//   a, b       dividend / divisor, bfloat16 {s, e[7:0], m[6:0]}
//   out_valid  quotient valid; held until out_ready
//   out_ready  downstream accepts the quotient
//   q          quotient, bfloat16
//   busy       high while computing or holding a result
module fdiv_bfloat16_seq #(
  parameter int QBITS = 9,    // 1 integer + 8 fraction bits; fixed by the format
  parameter int BIAS  = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] q,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state_reg, state_next;

  logic [7:0]        ma_reg, mb_reg;
  logic              sign_reg;
  logic signed [9:0] e_reg;
  logic [9:0]        r_reg;
  logic [QBITS-2:0]  quot_reg;   // earlier quotient bits; the newest bit joins in quot_new
  logic [3:0]        cnt_reg;
  logic [15:0]       q_reg;

  // ---------------- operand classification (evaluated at accept) ----------
  logic [7:0]        a_exp, b_exp;
  logic              a_zero, b_zero, a_inf, b_inf;
  logic              is_nan, is_inf, is_zero, special;
  logic              sign_in;
  logic [15:0]       special_q;
  logic signed [9:0] e_init;

  assign a_exp   = a[14:7];
  assign b_exp   = b[14:7];
  assign a_zero  = (a_exp == 8'h00);
  assign b_zero  = (b_exp == 8'h00);
  assign a_inf   = (a_exp == 8'hFF);
  assign b_inf   = (b_exp == 8'hFF);
  assign sign_in = a[15] ^ b[15];

  assign is_nan  = (a_zero & b_zero) | (a_inf & b_inf);
  assign is_inf  = b_zero | a_inf;
  assign is_zero = a_zero | b_inf;
  assign special = is_nan | is_inf | is_zero;

  // Priority order matters: 0/0 and inf/inf must win over the inf/zero rules.
  always_comb begin
    special_q = {sign_in, 15'h0000};
    if (is_nan)
      special_q = 16'h7FC0;
    else if (is_inf)
      special_q = {sign_in, 8'hFF, 7'h00};
  end

  assign e_init = $signed({2'b00, a_exp} - {2'b00, b_exp} + 10'(BIAS));

  // ---------------- one restoring-division step ---------------------------
  logic              ge;
  logic [9:0]        r_sub, r_shift;
  logic [QBITS-1:0]  quot_new;
  logic              last_iter;

  assign ge        = (r_reg >= {2'b00, mb_reg});
  assign r_sub     = ge ? (r_reg - {2'b00, mb_reg}) : r_reg;
  // r_sub < mb <= 255 after the step, so the shift never loses a set bit.
  assign r_shift   = r_sub << 1;
  assign quot_new  = {quot_reg, ge};
  assign last_iter = (cnt_reg == 4'(QBITS - 1));

  // ---------------- normalisation of the finished quotient ----------------
  // With both mantissas in [1,2) the quotient lies in (0.5,2), so at most
  // one left shift is needed: if the integer bit is 0, bit 7 is set.
  logic signed [9:0] exp_n;
  logic [6:0]        mant_n;
  logic [15:0]       norm_q;

  always_comb begin
    if (quot_new[QBITS-1]) begin
      exp_n  = e_reg;
      mant_n = quot_new[7:1];
    end else begin
      exp_n  = e_reg - 10'sd1;
      mant_n = quot_new[6:0];
    end
    if (exp_n >= 10'sd255)
      norm_q = {sign_reg, 8'hFF, 7'h00};
    else if (exp_n <= 10'sd0)
      norm_q = {sign_reg, 15'h0000};
    else
      norm_q = {sign_reg, exp_n[7:0], mant_n};
  end

  // ---------------- control FSM -------------------------------------------
  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) state_next = special ? DONE : CALC;
      CALC: if (last_iter) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- datapath registers ------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ma_reg   <= '0;
      mb_reg   <= '0;
      sign_reg <= 1'b0;
      e_reg    <= '0;
      r_reg    <= '0;
      quot_reg <= '0;
      cnt_reg  <= '0;
      q_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) begin
          ma_reg   <= {1'b1, a[6:0]};
          mb_reg   <= {1'b1, b[6:0]};
          sign_reg <= sign_in;
          e_reg    <= e_init;
          r_reg    <= {3'b001, a[6:0]};
          quot_reg <= '0;
          cnt_reg  <= '0;
          if (special) q_reg <= special_q;
        end
        CALC: begin
          r_reg    <= r_shift;
          quot_reg <= quot_new[QBITS-2:0];
          cnt_reg  <= cnt_reg + 4'd1;
          if (last_iter) q_reg <= norm_q;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign q         = q_reg;

endmodule

// File: tb/tb_fdiv_bfloat16_seq.sv
// Directed testbench for fdiv_bfloat16_seq. Each scenario task drives its
// own stimulus and compares outputs against hand-computed bfloat16 values.
module tb_fdiv_bfloat16_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fdiv_bfloat16_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .busy      (busy)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Full transaction: wait idle, present operands, count edges to out_valid,
  // check result, then accept it with a one-cycle out_ready pulse.
  task automatic do_op(input logic [15:0] op_a, input logic [15:0] op_b,
                       input logic [15:0] exp_q, input int exp_lat,
                       input string name);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL %s idle_wait: in_ready=%b required 1", name, in_ready);
    end
    a = op_a; b = op_b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    $display("[TB] %s a=%h b=%h q=%h latency=%0d", name, op_a, op_b, q, n);
    tests_run++;
    if (n != exp_lat) begin
      tests_failed++;
      $display("[TB] FAIL %s latency: got %0d required %0d", name, n, exp_lat);
    end
    tests_run++;
    if (q !== exp_q) begin
      tests_failed++;
      $display("[TB] FAIL %s q: got %h required %h", name, q, exp_q);
    end
    tests_run++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s done_flags: busy=%b in_ready=%b required 1/0", name, busy, in_ready);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL %s release: out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 16'h0; b = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || q !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: in_ready=%b out_valid=%b busy=%b q=%h required 1/0/0/0000",
               in_ready, out_valid, busy, q);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_idle: in_ready=%b out_valid=%b busy=%b required 1/0/0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_normal();
    do_op(16'h3FC0, 16'h4000, 16'h3F40, 9, "div_1p5_by_2");
    do_op(16'h3F80, 16'h4040, 16'h3EAA, 9, "div_1_by_3");
    do_op(16'h3F80, 16'h3F80, 16'h3F80, 9, "div_1_by_1");
    do_op(16'h40C0, 16'h4000, 16'h4040, 9, "div_6_by_2");
    do_op(16'hBFC0, 16'h4000, 16'hBF40, 9, "div_neg");
    do_op(16'h3FFF, 16'h3F80, 16'h3FFF, 9, "div_max_mant");
  endtask

  task automatic test_special();
    do_op(16'hC000, 16'h0000, 16'hFF80, 0, "div_by_zero");
    do_op(16'h0000, 16'h0000, 16'h7FC0, 0, "zero_by_zero");
    do_op(16'h7F80, 16'hFF80, 16'h7FC0, 0, "inf_by_inf");
    do_op(16'h7F80, 16'h3F80, 16'h7F80, 0, "inf_by_one");
    do_op(16'hBF80, 16'h7F80, 16'h8000, 0, "neg_by_inf");
    do_op(16'h0000, 16'h4000, 16'h0000, 0, "zero_by_two");
  endtask

  task automatic test_range();
    do_op(16'h7F00, 16'h0080, 16'h7F80, 9, "overflow");
    do_op(16'h0080, 16'h7F00, 16'h0000, 9, "underflow");
    do_op(16'h7F00, 16'h3F80, 16'h7F00, 9, "exp_254");
    do_op(16'h7F00, 16'h3F00, 16'h7F80, 9, "exp_255");
    do_op(16'h0080, 16'h3F80, 16'h0080, 9, "exp_1");
    do_op(16'h0080, 16'h3FC0, 16'h0000, 9, "exp_0_after_norm");
  endtask

  task automatic test_backpressure();
    int n;
    a = 16'h3FC0; b = 16'h4000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL hold_start: out_valid=%b required 1", out_valid);
    end
    // Offer a new operand pair during the hold; it must be ignored.
    a = 16'h3F80; b = 16'h4040; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b1 || q !== 16'h3F40 || in_ready !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL hold_cycle_%0d: out_valid=%b q=%h in_ready=%b required 1/3f40/0",
                 i, out_valid, q, in_ready);
      end
    end
    in_valid = 1'b0;
    $display("[TB] hold a=3fc0 b=4000 q=%h held 20 cycles", q);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL hold_release: out_valid=%b in_ready=%b busy=%b required 0/1/0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    do_op(16'h3F80, 16'h4040, 16'h3EAA, 9, "b2b_1");
    do_op(16'hC000, 16'h0000, 16'hFF80, 0, "b2b_2");
    do_op(16'h40C0, 16'h4000, 16'h4040, 9, "b2b_3");
  endtask

  task automatic test_reset_mid();
    logic seen;
    a = 16'h3FC0; b = 16'h4000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || q !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset: in_ready=%b out_valid=%b busy=%b q=%h required 1/0/0/0000",
               in_ready, out_valid, busy, q);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stale_result: out_valid pulse seen=%b required 0", seen);
    end
    $display("[TB] mid_reset dropped operation, no stale result");
    do_op(16'h3F80, 16'h4040, 16'h3EAA, 9, "after_reset");
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_range();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
